magic_ctl_bank: RTL and testbench

// - Next-generation magic-mode controller: NMI entry/exit sequencing, magic ROM mapping with signature check,

---
 rtl/magic_ctl_bank_if.sv | 19 +
 rtl/magic_ctl_bank.sv | 204 ++++++++++++++++++++
 tb/tb_magic_ctl_bank.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/magic_ctl_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus
// Brief    : Qualified CPU bus bundle (address, write data, strobes).
// Revision : 1.0
// ============================================================================
interface cpu_bus;
   logic [15:0] a;
   logic [7:0]  d;
   logic        mreq;
   logic        ioreq;
   logic        rd;
   logic        wr;
   logic        m1;

   modport master (output a, d, mreq, ioreq, rd, wr, m1);
   modport slave  (input  a, d, mreq, ioreq, rd, wr, m1);
endinterface
`default_nettype wire

// File: rtl/magic_ctl_bank.sv
`default_nettype none
// ============================================================================
// Module   : magic_ctl_bank
// Brief    : Magic-mode NMI/ROM-map sequencer plus config register bank.
//            MAGIC_READBACK_EN enables readback of registers 1..NREGS-1.
// Revision : 1.0
// ============================================================================
module magic_ctl_bank #(
   parameter int                 NREGS       = 16,
   parameter logic [NREGS*8-1:0] RESET_VALS  = '0,
   parameter logic [15:0]        ENTRY_ADDR  = 16'h0066,
   parameter logic [15:0]        EXIT_ADDR   = 16'hF000,
   parameter logic [15:0]        REMAP_ADDR  = 16'hF008,
   parameter logic [7:0]         SIG         = 8'hEB,
   parameter logic [7:0]         CFG_PORT    = 8'hFF,
   parameter int                 NMI_TIMEOUT = 4096
) (
   input  logic               clk28,
   input  logic               rst_n,
   cpu_bus.slave              bus,
   input  logic               n_int,
   input  logic               n_int_next,
   input  logic               magic_button,
   input  logic               pause_button,
   input  logic               div_automap,
   output logic               n_nmi,
   output logic               magic_mode,
   output logic               magic_map,
   output logic [NREGS*8-1:0] cfg_q,
   output logic [NREGS-1:0]   cfg_wstb,
   output logic [7:0]         d_out,
   output logic               d_out_active
);
   localparam int                 c_CNT_W    = $clog2(NMI_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NMI_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_ARMED       = 3'd1,
      S_CHECK       = 3'd2,
      S_MAPPED      = 3'd3,
      S_UNMAP       = 3'd4,
      S_REMAP_UNMAP = 3'd5,
      S_REMAP_WAIT  = 3'd6
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_chk_seen;
   logic               r_chk_match;
   logic               r_wr_prev;

   logic [7:0] w_idx;
   logic       w_m1_mem;
   logic       w_fetch;
   logic       w_cfg_port;
   logic       w_idx_in_range;
   logic       w_wr_hit;
   logic       w_wr_first;
   logic       w_rd_ok;
   logic       w_rd_hit;
   logic [7:0] w_regs [0:255];

   assign w_idx          = bus.a[15:8];
   assign w_m1_mem       = bus.m1 && bus.mreq;
   assign w_fetch        = w_m1_mem && bus.rd;
   assign w_cfg_port     = magic_map && (bus.a[7:0] == CFG_PORT);
   assign w_idx_in_range = ({1'b0, w_idx} < 9'(NREGS));
   assign w_wr_hit       = w_cfg_port && bus.ioreq && bus.wr && w_idx_in_range && (w_idx != 8'd0);
   // Strobe only on the first cycle of an OUT so long bus cycles pulse once
   assign w_wr_first     = w_wr_hit && !r_wr_prev;

`ifdef MAGIC_READBACK_EN
   assign w_rd_ok = w_idx_in_range;
`else
   assign w_rd_ok = (w_idx == 8'd0);
`endif
   assign w_rd_hit = w_cfg_port && bus.ioreq && bus.rd && w_rd_ok;

   genvar gi;
   generate
      for (gi = 0; gi < 256; gi++) begin : g_reg
         if (gi == 0) begin : g_status
            assign w_regs[gi] = {4'b0, div_automap, magic_mode, pause_button, magic_button};
         end else if (gi < NREGS) begin : g_cfg
            logic [7:0] r_val;
            logic       r_stb;
            always_ff @(posedge clk28 or negedge rst_n) begin
               if (!rst_n) begin
                  r_val <= RESET_VALS[gi*8 +: 8];
                  r_stb <= 1'b0;
               end else begin
                  r_stb <= w_wr_first && (w_idx == 8'(gi));
                  if (w_wr_hit && (w_idx == 8'(gi)))
                     r_val <= bus.d;
               end
            end
            assign w_regs[gi]        = r_val;
            assign cfg_q[gi*8 +: 8]  = r_val;
            assign cfg_wstb[gi]      = r_stb;
         end else begin : g_none
            assign w_regs[gi] = 8'h00;
         end
      end
   endgenerate

   assign cfg_q[7:0]  = 8'h00;
   assign cfg_wstb[0] = 1'b0;

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         d_out_active <= 1'b0;
         d_out        <= 8'h00;
      end else begin
         d_out_active <= w_rd_hit;
         if (w_rd_hit)
            d_out <= w_regs[w_idx];
      end
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_CHECK;
         n_nmi       <= 1'b1;
         magic_mode  <= 1'b1;
         magic_map   <= 1'b1;
         r_cnt       <= '0;
         r_chk_seen  <= 1'b0;
         r_chk_match <= 1'b0;
         r_wr_prev   <= 1'b0;
      end else begin
         r_wr_prev <= bus.ioreq && bus.wr;
         case (r_state)
            S_IDLE: begin
               if ((magic_button || pause_button) && n_int && !n_int_next) begin
                  n_nmi      <= 1'b0;
                  magic_mode <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_m1_mem && (bus.a == ENTRY_ADDR)) begin
                  n_nmi     <= 1'b1;
                  magic_map <= 1'b1;
                  r_state   <= S_CHECK;
               end else if (r_cnt == c_CNT_LAST) begin
                  // CPU never took the NMI: give up the session
                  n_nmi      <= 1'b1;
                  magic_mode <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (r_cnt != {c_CNT_W{1'b1}}) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (w_fetch) begin
                  if (!r_chk_seen) begin
                     r_chk_seen  <= 1'b1;
                     r_chk_match <= (bus.d == SIG);
                  end
               end else if (r_chk_seen) begin
                  r_chk_seen <= 1'b0;
                  if (r_chk_match) begin
                     r_state <= S_MAPPED;
                  end else begin
                     magic_mode <= 1'b0;
                     magic_map  <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_MAPPED: begin
               if (bus.mreq && bus.rd && (bus.a == EXIT_ADDR)) begin
                  magic_mode <= 1'b0;
                  r_state    <= S_UNMAP;
               end else if (bus.mreq && bus.rd && (bus.a == REMAP_ADDR)) begin
                  r_state <= S_REMAP_UNMAP;
               end
            end
            S_UNMAP: begin
               if (!bus.mreq) begin
                  magic_map <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            S_REMAP_UNMAP: begin
               if (!bus.mreq) begin
                  magic_map <= 1'b0;
                  r_state   <= S_REMAP_WAIT;
               end
            end
            S_REMAP_WAIT: begin
               if (w_m1_mem) begin
                  magic_map <= 1'b1;
                  r_state   <= (bus.a == ENTRY_ADDR) ? S_CHECK : S_MAPPED;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_magic_ctl_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_magic_ctl_bank
// Brief    : Directed/randomized bench for magic_ctl_bank with a register-bank
//            model; honours MAGIC_READBACK_EN for read expectations.
// Revision : 1.0
// ============================================================================
module tb_magic_ctl_bank;
   localparam int                 NREGS    = 16;
   localparam int                 TMO      = 16;
   localparam logic [NREGS*8-1:0] RST_VALS = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

   logic clk28 = 1'b0;
   logic rst_n = 1'b0;
   logic n_int = 1'b1, n_int_next = 1'b1;
   logic magic_button = 1'b0, pause_button = 1'b0, div_automap = 1'b0;
   logic n_nmi, magic_mode, magic_map, d_out_active;
   logic [NREGS*8-1:0] cfg_q;
   logic [NREGS-1:0]   cfg_wstb;
   logic [7:0]         d_out;

   cpu_bus bus();

   magic_ctl_bank #(.NREGS(NREGS), .RESET_VALS(RST_VALS), .NMI_TIMEOUT(TMO)) dut (
      .clk28(clk28), .rst_n(rst_n), .bus(bus.slave),
      .n_int(n_int), .n_int_next(n_int_next),
      .magic_button(magic_button), .pause_button(pause_button), .div_automap(div_automap),
      .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
      .cfg_q(cfg_q), .cfg_wstb(cfg_wstb), .d_out(d_out), .d_out_active(d_out_active)
   );

   always #5 clk28 = ~clk28;

   int         n_asserts = 0;
   int         n_fail    = 0;
   logic [7:0] m_regs [NREGS];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   task automatic bus_idle();
      bus.a = '0; bus.d = '0; bus.mreq = 1'b0; bus.ioreq = 1'b0;
      bus.rd = 1'b0; bus.wr = 1'b0; bus.m1 = 1'b0;
   endtask

   task automatic model_reset();
      m_regs[0] = 8'h00;
      for (int i = 1; i < NREGS; i++) m_regs[i] = RST_VALS[i*8 +: 8];
   endtask

   function automatic logic [NREGS*8-1:0] m_cfg_q();
      logic [NREGS*8-1:0] r;
      r = '0;
      for (int i = 1; i < NREGS; i++) r[i*8 +: 8] = m_regs[i];
      return r;
   endfunction

   task automatic fetch(input logic [15:0] addr, input logic [7:0] op);
      bus.a = addr; bus.d = op; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick(); tick();
      bus_idle(); tick();
   endtask

   task automatic cfg_write(input logic [7:0] idx, input logic [7:0] val, input logic mapped);
      logic valid;
      valid = mapped && (idx != 8'd0) && (idx < NREGS);
      bus.a = {idx, 8'hFF}; bus.d = val; bus.ioreq = 1'b1; bus.wr = 1'b1;
      tick();
      if (valid) m_regs[idx] = val;
      chk("wr_cfg_q", cfg_q, m_cfg_q());
      chk("wr_stb", cfg_wstb, valid ? (128'd1 << idx) : 128'd0);
      tick();
      chk("wr_stb_once", cfg_wstb, 0);
      bus_idle(); tick();
   endtask

   task automatic cfg_read(input logic [7:0] idx, input logic mapped, input logic mode);
      logic       ok;
      logic [7:0] expd;
`ifdef MAGIC_READBACK_EN
      ok = mapped && (idx < NREGS);
`else
      ok = mapped && (idx == 8'd0);
`endif
      if (idx == 8'd0) expd = {4'b0, div_automap, mode, pause_button, magic_button};
      else if (idx < NREGS) expd = m_regs[idx];
      else expd = 8'h00;
      bus.a = {idx, 8'hFF}; bus.ioreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("rd_active", d_out_active, ok);
      if (ok) chk("rd_data", d_out, expd);
      bus_idle(); tick();
      chk("rd_active_drop", d_out_active, 0);
   endtask

   initial begin
      int         k;
      logic [7:0] op;
      bus_idle();
      model_reset();
      repeat (3) @(posedge clk28);
      #1;
      chk("rst_n_nmi", n_nmi, 1);
      chk("rst_mode", magic_mode, 1);
      chk("rst_map", magic_map, 1);
      chk("rst_cfg_q", cfg_q, m_cfg_q());
      chk("rst_wstb", cfg_wstb, 0);
      chk("rst_d_act", d_out_active, 0);
      rst_n = 1'b1;
      tick();

      // Correct signature keeps the ROM mapped
      fetch(16'h0000, 8'hEB);
      chk("sig_ok_map", magic_map, 1);
      chk("sig_ok_mode", magic_mode, 1);

      for (int i = 0; i < 6; i++)
         cfg_write(8'($urandom_range(1, NREGS - 1)), 8'($urandom), 1'b1);
      cfg_write(8'd3, 8'h5A, 1'b1);
      cfg_write(8'd0, 8'($urandom), 1'b1);
      cfg_write(8'h40, 8'hC3, 1'b1);
      cfg_write(8'($urandom_range(NREGS, 255)), 8'($urandom), 1'b1);

      div_automap  = 1'($urandom);
      magic_button = 1'($urandom);
      pause_button = 1'($urandom);
      cfg_read(8'd0, 1'b1, 1'b1);
      cfg_read(8'd3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         cfg_read(8'($urandom_range(0, NREGS - 1)), 1'b1, 1'b1);
      cfg_read(8'($urandom_range(NREGS, 255)), 1'b1, 1'b1);
      magic_button = 1'b0;
      pause_button = 1'b0;

      // Exit: mode drops at the read, map only once mreq falls
      bus.a = 16'hF000; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("exit_mode", magic_mode, 0);
      chk("exit_map_held", magic_map, 1);
      tick();
      chk("exit_map_held2", magic_map, 1);
      bus_idle(); tick();
      chk("exit_unmap", magic_map, 0);
      cfg_write(8'd3, 8'hA5, 1'b0);
      cfg_read(8'd0, 1'b0, 1'b0);

      // NMI entry
      magic_button = 1'b1; n_int_next = 1'b0;
      tick();
      chk("nmi_low", n_nmi, 0);
      chk("nmi_mode", magic_mode, 1);
      magic_button = 1'b0; n_int_next = 1'b1;
      repeat ($urandom_range(1, 8)) tick();
      chk("nmi_held", n_nmi, 0);
      bus.a = 16'h0066; bus.d = 8'hEB; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("entry_nmi_rel", n_nmi, 1);
      chk("entry_map", magic_map, 1);
      tick();
      bus_idle(); tick(); tick();
      chk("entry_mode", magic_mode, 1);
      chk("entry_map_kept", magic_map, 1);

      // Remap sequence
      bus.a = 16'hF008; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("remap_map_held", magic_map, 1);
      bus_idle(); tick();
      chk("remap_unmap", magic_map, 0);
      chk("remap_mode", magic_mode, 1);
      tick();
      chk("remap_wait", magic_map, 0);
      bus.a = 16'($urandom_range(16'h0100, 16'hEFFF)); bus.d = 8'($urandom);
      bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("remap_map", magic_map, 1);
      bus_idle(); tick();
      cfg_write(8'($urandom_range(1, NREGS - 1)), 8'($urandom), 1'b1);
      bus.a = 16'hF000; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      bus_idle(); tick();
      chk("exit2_mode", magic_mode, 0);
      chk("exit2_map", magic_map, 0);

      // NMI never acknowledged
      pause_button = 1'b1; n_int_next = 1'b0;
      tick();
      pause_button = 1'b0; n_int_next = 1'b1;
      chk("tmo_nmi_low", n_nmi, 0);
      k = 0;
      while (n_nmi !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      chk("tmo_cycles", k, TMO);
      chk("tmo_mode", magic_mode, 0);
      chk("tmo_map", magic_map, 0);

      // Entry with a bad signature
      magic_button = 1'b1; n_int_next = 1'b0;
      tick();
      magic_button = 1'b0; n_int_next = 1'b1;
      do op = 8'($urandom); while (op == 8'hEB);
      bus.a = 16'h0066; bus.d = op; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
      tick();
      chk("bad_nmi_rel", n_nmi, 1);
      chk("bad_map_on", magic_map, 1);
      tick();
      bus_idle(); tick();
      chk("bad_mode", magic_mode, 0);
      chk("bad_map", magic_map, 0);

      // Asynchronous reset in the middle of an armed NMI
      magic_button = 1'b1; n_int_next = 1'b0;
      tick();
      magic_button = 1'b0; n_int_next = 1'b1;
      chk("pre_rst_nmi", n_nmi, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_nmi", n_nmi, 1);
      chk("arst_mode", magic_mode, 1);
      chk("arst_map", magic_map, 1);
      chk("arst_cfg_q", cfg_q, m_cfg_q());
      tick();
      rst_n = 1'b1;
      tick();
      fetch(16'h0000, 8'h00);
      chk("sig_bad_mode", magic_mode, 0);
      chk("sig_bad_map", magic_map, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
